gpr_exec_unit: RTL and testbench
================================

// Module: gpr_exec_unit
// PURPOSE
//  Parametrised register-file + execute unit; successor to the fixed 16-bit combinational GPR/ALU in top.
//  Accepts 32-bit instructions over a valid/ready handshake, executes arith/logic ops, writes GPR, updates flags.
//  Multi-cycle shift-add multiplier fills SGPR (high half). Sits between fetch/decode and future load/store stage.
// PARAMETERS
//  DATA_W   16  GPR/SGPR/operand width (8..32)
//  GPR_NUM  32  number of GPRs (2..32); instruction reg fields remain 5 bits
// PORTS
//  clk          in   1       clock, rising edge
//  sys_rst      in   1       synchronous, active-high reset
//  instr_valid  in   1       instruction offered
//  instr_ready  out  1       unit idle, can accept
//  instr        in   32      [31:27]oper_type [26:22]rdst [21:17]rsrc1 [16]imm_mode [15:11]rsrc2 [15:0]isrc
//  done         out  1       1-cycle pulse: result written
//  err          out  1       1-cycle pulse: illegal opcode/address, nothing written
//  flags        out  4       {sign,zero,carry,overflow}
//  sgpr         out  DATA_W  special register (mul high half)
//  ld_en        in   1       bench/boot GPR load strobe
//  ld_addr      in   5       load address
//  ld_data      in   DATA_W  load data
//  rd_addr      in   5       debug read address
//  rd_data      out  DATA_W  GPR[rd_addr], combinational; 0 if rd_addr>=GPR_NUM
// BEHAVIOUR
//  Reset: instr_ready=1, done=0, err=0, flags=0, sgpr=0, all GPR=0, state=IDLE; aborts any op, no writeback.
//  FSM: IDLE --(valid&ready)--> EXEC; EXEC --(mul)--> MUL, else --> IDLE; MUL --(DATA_W iters)--> IDLE.
//  instr latched on accept; instr_ready=1 only in IDLE; instr changes while busy are ignored.
//  Opcodes: 0 movsgpr(rdst=SGPR) 1 mov 2 add 3 sub 4 mul 5 or 6 and 7 xor 8 xnor 9 nand 10 nor 11 not(rsrc1).
//  Operand2 = imm_mode ? isrc zero-extended/truncated to DATA_W : GPR[rsrc2].
//  Latency: non-mul accepted at edge N -> GPR/flags written and done=1 after edge N+1; ready=1 same cycle.
//  mul: one shift-add iteration per cycle in MUL; write after edge N+1+DATA_W; GPR=low, SGPR=high half.
//  Flags updated on every successful writeback: zero=(result==0), sign=result[DATA_W-1];
//   add: carry=carry-out, overflow=signed ovf; sub: carry=borrow, overflow=signed ovf;
//   mul: carry=0, overflow=(high half!=0); movsgpr/mov/logic: carry=0, overflow=0.
//  err: opcode>11, or rdst/rsrc1/rsrc2(reg mode) >= GPR_NUM -> err pulse after edge N+1, no GPR/flag/SGPR change.
//  ld_en: writes GPR[ld_addr] any cycle; ignored if ld_addr>=GPR_NUM; same-cycle writeback to same addr wins.
//  rdst==rsrc1 allowed: operands sampled at EXEC, before write.
//  Back-to-back: new instr accepted cycle after done; no pipelining overlap.
// CONFIGURATION
//  EXEC_MUL_EN defined: opcode 4 runs the multi-cycle multiplier as above.
//  EXEC_MUL_EN undefined: no multiplier logic; opcode 4 treated as illegal (err pulse, no write); SGPR stays 0,
//   movsgpr still legal and returns 0.
// TESTING
//  Reset mid-mul (sys_rst 1 cycle during MUL) -> ready=1, done never pulses, target GPR unchanged, SGPR=0.
//  OR: GPR4=0x0AD2, GPR16=0x660E, rdst=0 -> GPR0=0x6EDE, done 1 cycle after accept, flags zero=0,sign=0.
//  NOR same operands -> GPR0=0x9121, sign=1; NOT GPR6=0xCADA -> GPR0=0x3525.
//  ADD imm: GPR1=0xFFFF + isrc 0x0001 -> GPR0=0x0000, zero=1, carry=1, overflow=0.
//  MUL (EXEC_MUL_EN): 0x0100*0x0100 -> GPR0=0x0000, SGPR=0x0001, overflow=1, done 17 cycles after accept;
//   then movsgpr rdst=3 -> GPR3=0x0001. Without macro -> err pulse, GPR0 unchanged.
//  Illegal: oper_type=15, then GPR_NUM=8 with rdst=9 -> err pulse each, no GPR/flag change, ready returns.

Source files
------------

// File: rtl/gpr_exec_unit.sv
// gpr_exec_unit: parametrised GPR file + execute unit fed by a valid/ready instruction port.
// Build option: define EXEC_MUL_EN to include the shift-add multiplier; without it opcode 4 is illegal.
module gpr_exec_unit #(
    parameter int DATA_W  = 16,
    parameter int GPR_NUM = 32
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              done,
    output logic              err,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] sgpr,
    input  logic              ld_en,
    input  logic [4:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int         REG_SLOTS = 32;
    localparam logic [5:0] GPR_LIM   = 6'(GPR_NUM);

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_gpr [REG_SLOTS];
    logic [DATA_W-1:0] r_sgpr;
    logic [3:0]        r_flags;
    logic              r_done;
    logic              r_err;

    function automatic logic in_range(input logic [4:0] a);
        return ({1'b0, a} < GPR_LIM);
    endfunction

    // Signed overflow: the sign-extended result disagrees with its truncated MSB.
    function automatic logic signed_ovf(input logic signed [DATA_W-1:0] a,
                                        input logic signed [DATA_W-1:0] b,
                                        input logic                     sub);
        logic signed [DATA_W:0] a_x;
        logic signed [DATA_W:0] b_x;
        logic signed [DATA_W:0] s_x;
        a_x = {a[DATA_W-1], a};
        b_x = {b[DATA_W-1], b};
        s_x = sub ? (a_x - b_x) : (a_x + b_x);
        return (s_x[DATA_W] != s_x[DATA_W-1]);
    endfunction

    function automatic logic [3:0] mk_flags(input logic [DATA_W-1:0] r,
                                            input logic c, input logic v);
        return {r[DATA_W-1], (r == '0), c, v};
    endfunction

    logic [4:0]        w_op;
    logic [4:0]        w_rdst;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic              w_imm;
    logic [15:0]       w_isrc;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_op_bad;
    logic              w_illegal;
    logic [DATA_W-1:0] w_res;
    logic              w_carry;
    logic              w_ovf;

    assign w_op   = r_instr[31:27];
    assign w_rdst = r_instr[26:22];
    assign w_rs1  = r_instr[21:17];
    assign w_imm  = r_instr[16];
    assign w_rs2  = r_instr[15:11];
    assign w_isrc = r_instr[15:0];

    assign w_a = r_gpr[w_rs1];
    assign w_b = w_imm ? DATA_W'(w_isrc) : r_gpr[w_rs2];

`ifdef EXEC_MUL_EN
    assign w_op_bad = (w_op > OP_NOT);
`else
    assign w_op_bad = (w_op > OP_NOT) || (w_op == OP_MUL);
`endif
    assign w_illegal = w_op_bad || !in_range(w_rdst) || !in_range(w_rs1) ||
                       (!w_imm && !in_range(w_rs2));

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (w_op)
            OP_MOVSGPR: w_res = r_sgpr;
            OP_MOV:     w_res = w_imm ? DATA_W'(w_isrc) : w_a;
            OP_ADD: begin
                {w_carry, w_res} = {1'b0, w_a} + {1'b0, w_b};
                w_ovf            = signed_ovf(w_a, w_b, 1'b0);
            end
            OP_SUB: begin
                {w_carry, w_res} = {1'b0, w_a} - {1'b0, w_b};
                w_ovf            = signed_ovf(w_a, w_b, 1'b1);
            end
            OP_OR:   w_res = w_a | w_b;
            OP_AND:  w_res = w_a & w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            OP_XNOR: w_res = ~(w_a ^ w_b);
            OP_NAND: w_res = ~(w_a & w_b);
            OP_NOR:  w_res = ~(w_a | w_b);
            OP_NOT:  w_res = ~w_a;
            default: ;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic [DATA_W-1:0]   r_mcand;
    logic [2*DATA_W-1:0] r_prod;
    logic [5:0]          r_cnt;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_prod_nxt;
    logic                w_mul_last;

    // Product register holds {high, multiplier}; each step adds and shifts right by one.
    assign w_mul_sum  = {1'b0, r_prod[2*DATA_W-1:DATA_W]} +
                        (r_prod[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
    assign w_prod_nxt = {w_mul_sum, r_prod[DATA_W-1:1]};
    assign w_mul_last = (r_cnt == 6'(DATA_W-1));

    always_ff @(posedge clk) begin
        if (r_state == S_EXEC) begin
            r_mcand <= w_a;
            r_prod  <= {{DATA_W{1'b0}}, w_b};
            r_cnt   <= '0;
        end else if (r_state == S_MUL) begin
            r_prod  <= w_prod_nxt;
            r_cnt   <= r_cnt + 6'd1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (instr_valid) w_state_nxt = S_EXEC;
            S_EXEC: begin
                w_state_nxt = S_IDLE;
`ifdef EXEC_MUL_EN
                if (!w_illegal && (w_op == OP_MUL)) w_state_nxt = S_MUL;
`endif
            end
            S_MUL: begin
`ifdef EXEC_MUL_EN
                if (w_mul_last) w_state_nxt = S_IDLE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && instr_valid) r_instr <= instr;
    end

    // Writeback is placed after the load strobe so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_flags <= '0;
            r_sgpr  <= '0;
            for (int i = 0; i < REG_SLOTS; i++) r_gpr[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (ld_en && in_range(ld_addr)) r_gpr[ld_addr] <= ld_data;
            case (r_state)
                S_EXEC: begin
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end else if (w_op != OP_MUL) begin
                        r_gpr[w_rdst] <= w_res;
                        r_flags       <= mk_flags(w_res, w_carry, w_ovf);
                        r_done        <= 1'b1;
                    end
                end
`ifdef EXEC_MUL_EN
                S_MUL: begin
                    if (w_mul_last) begin
                        r_gpr[w_rdst] <= w_prod_nxt[DATA_W-1:0];
                        r_sgpr        <= w_prod_nxt[2*DATA_W-1:DATA_W];
                        r_flags       <= mk_flags(w_prod_nxt[DATA_W-1:0], 1'b0,
                                                  (w_prod_nxt[2*DATA_W-1:DATA_W] != '0));
                        r_done        <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign flags       = r_flags;
    assign sgpr        = r_sgpr;
    assign rd_data     = in_range(rd_addr) ? r_gpr[rd_addr] : '0;

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Table-driven bench for gpr_exec_unit: ALU vectors plus hand sequences for mul, errors and reset.
// Expectations for opcode 4 follow the EXEC_MUL_EN build option.
module tb_gpr_exec_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_rst, instr_valid, instr_ready, done, err, ld_en;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [15:0] sgpr, ld_data, rd_data;
    logic [4:0]  ld_addr, rd_addr;

    logic        instr_valid8, instr_ready8, done8, err8, ld_en8;
    logic [31:0] instr8;
    logic [3:0]  flags8;
    logic [15:0] sgpr8, ld_data8, rd_data8;
    logic [4:0]  ld_addr8, rd_addr8;

    gpr_exec_unit #(.DATA_W(16), .GPR_NUM(32)) u_dut (
        .clk(clk), .sys_rst(sys_rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .done(done), .err(err), .flags(flags), .sgpr(sgpr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    gpr_exec_unit #(.DATA_W(16), .GPR_NUM(8)) u_dut8 (
        .clk(clk), .sys_rst(sys_rst), .instr_valid(instr_valid8), .instr_ready(instr_ready8),
        .instr(instr8), .done(done8), .err(err8), .flags(flags8), .sgpr(sgpr8),
        .ld_en(ld_en8), .ld_addr(ld_addr8), .ld_data(ld_data8), .rd_addr(rd_addr8), .rd_data(rd_data8)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rdst;
        logic [4:0]  rs1;
        logic        imm;
        logic [15:0] src;
        logic [15:0] exp_val;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rdst,
                                       input logic [4:0] rs1, input logic imm,
                                       input logic [15:0] src);
        return {op, rdst, rs1, imm, (imm ? src : {src[4:0], 11'b0})};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic ld(input logic [4:0] a, input logic [15:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [15:0] v);
        rd_addr = a; #1;
        v = rd_data;
    endtask

    // Issue one instruction and wait (bounded) for done/err; lat=0 means it never came.
    task automatic run(input logic [31:0] ins, output int lat, output logic e,
                       output logic d, output int rdyc);
        lat = 0; e = 1'b0; d = 1'b0; rdyc = 0;
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done || err) begin
                lat = k; e = err; d = done;
                break;
            end
            if (instr_ready) rdyc++;
        end
    endtask

    task automatic run8(input logic [31:0] ins, output int lat, output logic e, output logic d);
        lat = 0; e = 1'b0; d = 1'b0;
        @(negedge clk);
        instr8 = ins; instr_valid8 = 1'b1;
        @(posedge clk); #1;
        instr_valid8 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8 || err8) begin
                lat = k; e = err8; d = done8;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          lat, rdyc, dcnt;
        logic        e, d;
        logic [15:0] v;
        logic [3:0]  fl_exp;

        sys_rst = 1'b1; instr_valid = 1'b0; instr = '0; ld_en = 1'b0; ld_addr = '0;
        ld_data = '0; rd_addr = '0;
        instr_valid8 = 1'b0; instr8 = '0; ld_en8 = 1'b0; ld_addr8 = '0; ld_data8 = '0;
        rd_addr8 = '0;
        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b0;

        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_flags", flags, 0);
        chk("rst_sgpr", sgpr, 0);
        rd(5'd5, v);
        chk("rst_gpr5", v, 0);

        ld(5'd4, 16'h0AD2);  ld(5'd16, 16'h660E); ld(5'd6, 16'hCADA);
        ld(5'd1, 16'hFFFF);  ld(5'd2, 16'h7FFF);  ld(5'd5, 16'h0100);
        ld(5'd17, 16'h0005); ld(5'd18, 16'h1234);
        rd(5'd16, v);
        chk("load_gpr16", v, 16'h660E);

        //               op     rdst    rs1    imm   src         exp_val   flags
        tbl[0]  = '{5'd5,  5'd0,  5'd4,  1'b0, 16'd16,     16'h6EDE, 4'b0000};
        tbl[1]  = '{5'd10, 5'd0,  5'd4,  1'b0, 16'd16,     16'h9121, 4'b1000};
        tbl[2]  = '{5'd11, 5'd0,  5'd6,  1'b0, 16'd0,      16'h3525, 4'b0000};
        tbl[3]  = '{5'd2,  5'd0,  5'd1,  1'b1, 16'h0001,   16'h0000, 4'b0110};
        tbl[4]  = '{5'd6,  5'd7,  5'd4,  1'b0, 16'd16,     16'h0202, 4'b0000};
        tbl[5]  = '{5'd7,  5'd8,  5'd4,  1'b0, 16'd16,     16'h6CDC, 4'b0000};
        tbl[6]  = '{5'd8,  5'd9,  5'd4,  1'b0, 16'd16,     16'h9323, 4'b1000};
        tbl[7]  = '{5'd9,  5'd10, 5'd4,  1'b0, 16'd16,     16'hFDFD, 4'b1000};
        tbl[8]  = '{5'd3,  5'd11, 5'd4,  1'b0, 16'd16,     16'hA4C4, 4'b1010};
        tbl[9]  = '{5'd2,  5'd12, 5'd2,  1'b1, 16'h0001,   16'h8000, 4'b1001};
        tbl[10] = '{5'd3,  5'd13, 5'd2,  1'b1, 16'h7FFF,   16'h0000, 4'b0100};
        tbl[11] = '{5'd1,  5'd14, 5'd0,  1'b1, 16'h1234,   16'h1234, 4'b0000};
        tbl[12] = '{5'd3,  5'd15, 5'd6,  1'b1, 16'h7FFF,   16'h4ADB, 4'b0001};
        tbl[13] = '{5'd2,  5'd17, 5'd17, 1'b1, 16'h0003,   16'h0008, 4'b0000};
        tbl[14] = '{5'd0,  5'd3,  5'd0,  1'b1, 16'h0000,   16'h0000, 4'b0100};

        for (int i = 0; i < 15; i++) begin
            run(mk(tbl[i].op, tbl[i].rdst, tbl[i].rs1, tbl[i].imm, tbl[i].src), lat, e, d, rdyc);
            chk($sformatf("v%0d_latency", i), lat, 1);
            chk($sformatf("v%0d_done", i), {e, d}, 2'b01);
            chk($sformatf("v%0d_ready", i), instr_ready, 1);
            chk($sformatf("v%0d_flags", i), flags, tbl[i].exp_flags);
            rd(tbl[i].rdst, v);
            chk($sformatf("v%0d_result", i), v, tbl[i].exp_val);
        end

        // Writeback and load strobe hit the same register on the same edge.
        @(negedge clk);
        instr = mk(5'd2, 5'd22, 5'd4, 1'b1, 16'h0001); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 5'd22; ld_data = 16'hAAAA;
        @(posedge clk); #1;
        ld_en = 1'b0;
        chk("collide_done", done, 1);
        rd(5'd22, v);
        chk("collide_wb_wins", v, 16'h0AD3);

        ld(5'd0, 16'h7777);
`ifdef EXEC_MUL_EN
        run(mk(5'd4, 5'd0, 5'd5, 1'b1, 16'h0100), lat, e, d, rdyc);
        chk("mul1_latency", lat, 17);
        chk("mul1_done", {e, d}, 2'b01);
        chk("mul1_busy_ready", rdyc, 0);
        chk("mul1_sgpr", sgpr, 16'h0001);
        chk("mul1_flags", flags, 4'b0101);
        rd(5'd0, v);
        chk("mul1_low", v, 16'h0000);
        run(mk(5'd0, 5'd3, 5'd0, 1'b1, 16'h0000), lat, e, d, rdyc);
        chk("movsgpr_done", {e, d}, 2'b01);
        rd(5'd3, v);
        chk("movsgpr_val", v, 16'h0001);
        run(mk(5'd4, 5'd20, 5'd18, 1'b1, 16'h0010), lat, e, d, rdyc);
        chk("mul2_latency", lat, 17);
        rd(5'd20, v);
        chk("mul2_low", v, 16'h2340);
        chk("mul2_sgpr", sgpr, 16'h0001);
        chk("mul2_flags", flags, 4'b0001);
        fl_exp = 4'b0001;
`else
        run(mk(5'd4, 5'd0, 5'd5, 1'b1, 16'h0100), lat, e, d, rdyc);
        chk("mul_latency", lat, 1);
        chk("mul_err", {e, d}, 2'b10);
        rd(5'd0, v);
        chk("mul_no_write", v, 16'h7777);
        chk("mul_flags_kept", flags, 4'b0000);
        chk("mul_sgpr_zero", sgpr, 16'h0000);
        fl_exp = 4'b0000;
`endif

        ld(5'd0, 16'h7777);
        run(mk(5'd15, 5'd0, 5'd4, 1'b0, 16'd16), lat, e, d, rdyc);
        chk("ill_op_latency", lat, 1);
        chk("ill_op_err", {e, d}, 2'b10);
        chk("ill_op_ready", instr_ready, 1);
        chk("ill_op_flags", flags, fl_exp);
        rd(5'd0, v);
        chk("ill_op_no_write", v, 16'h7777);

        // Eight-register instance: addresses at or above 8 are out of range.
        run8(mk(5'd2, 5'd9, 5'd0, 1'b1, 16'h0005), lat, e, d);
        chk("g8_rdst_err", {e, d}, 2'b10);
        chk("g8_rdst_flags", flags8, 4'b0000);
        chk("g8_ready", instr_ready8, 1);
        run8(mk(5'd2, 5'd1, 5'd0, 1'b1, 16'h0005), lat, e, d);
        chk("g8_add_done", {e, d}, 2'b01);
        rd_addr8 = 5'd1; #1;
        chk("g8_add_val", rd_data8, 16'h0005);
        run8(mk(5'd2, 5'd1, 5'd0, 1'b0, 16'd12), lat, e, d);
        chk("g8_rs2_err", {e, d}, 2'b10);
        #1;
        chk("g8_rs2_no_write", rd_data8, 16'h0005);
        @(negedge clk);
        ld_en8 = 1'b1; ld_addr8 = 5'd9; ld_data8 = 16'hBEEF;
        @(posedge clk); #1;
        ld_en8 = 1'b0; rd_addr8 = 5'd9; #1;
        chk("g8_oob_read", rd_data8, 16'h0000);

        // Reset while an instruction is in flight.
        @(negedge clk);
        instr = mk(5'd4, 5'd21, 5'd18, 1'b1, 16'h0010); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
`ifdef EXEC_MUL_EN
        repeat (5) @(posedge clk);
        #1;
`endif
        chk("abort_busy", instr_ready, 0);
        sys_rst = 1'b1;
        @(posedge clk); #1;
        sys_rst = 1'b0;
        chk("abort_ready", instr_ready, 1);
        chk("abort_sgpr", sgpr, 16'h0000);
        chk("abort_flags", flags, 4'b0000);
        dcnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        rd(5'd21, v);
        chk("abort_target", v, 16'h0000);
        rd(5'd4, v);
        chk("abort_gpr_cleared", v, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
